// File: rtl/fp_round_pipe_if.sv
// Handshake bundle for the FP normalise+round pipe: input beat, result beat and flags.
interface fp_round_pipe_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int PROD_WIDTH = 2 * (MANT_WIDTH + 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PROD_WIDTH-1:0]   in_prod;
  logic [EXP_WIDTH+1:0]    in_exp;
  logic                    in_sign;
  logic [1:0]              in_rmode;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic [EXP_WIDTH-1:0]    out_exp;
  logic [MANT_WIDTH-1:0]   out_mant;
  logic                    out_inexact;
  logic                    out_overflow;
  logic                    out_underflow;

  modport master (
    output in_valid, in_prod, in_exp, in_sign, in_rmode, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
           out_inexact, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_prod, in_exp, in_sign, in_rmode, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
           out_inexact, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage normalise (stage 1) and round/saturate/flush (stage 2) for the FP multiplier.
module fp_round_pipe #(
  parameter int IS_DOUBLE  = 0,
  parameter int EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
  parameter int MANT_WIDTH = IS_DOUBLE ? 52 : 23,
  parameter int PROD_WIDTH = 2 * (MANT_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fp_round_pipe_if.slave   bus
);
  localparam int E = EXP_WIDTH;
  localparam int M = MANT_WIDTH;
  localparam int P = PROD_WIDTH;
  localparam int STAGES = 2;
  localparam logic [E+2:0] EXP_INF = (E+3)'((1 << E) - 1);

  typedef struct packed {
    logic          sign;
    logic [1:0]    rmode;
    logic          zero;
    logic [E+1:0]  exp;
    logic [M-1:0]  mant;
    logic          guard;
    logic          sticky;
  } norm_t;

  typedef struct packed {
    logic          sign;
    logic [E-1:0]  exp;
    logic [M-1:0]  mant;
    logic          inexact;
    logic          overflow;
    logic          underflow;
  } res_t;

  logic [STAGES:1] vld_pipe;
  norm_t           s1_n, s1_q;
  res_t            res_n, res_q;
  logic            s2_load, s1_moves, in_ready, top;

  assign s2_load  = !vld_pipe[2] || bus.out_ready;
  assign s1_moves = vld_pipe[1] && s2_load;
  assign in_ready = !vld_pipe[1] || s1_moves;

  // Product in [2,4) keeps the window at the top; in [1,2) it slides down one bit.
  assign top = bus.in_prod[P-1];

  always_comb begin
    s1_n        = '0;
    s1_n.sign   = bus.in_sign;
    s1_n.rmode  = bus.in_rmode;
    s1_n.zero   = (bus.in_prod == '0);
    s1_n.exp    = bus.in_exp + {{(E+1){1'b0}}, top};
    s1_n.mant   = top ? bus.in_prod[P-2 -: M] : bus.in_prod[P-3 -: M];
    s1_n.guard  = top ? bus.in_prod[P-M-2]    : bus.in_prod[P-M-3];
    s1_n.sticky = top ? |bus.in_prod[P-M-3:0] : |bus.in_prod[P-M-4:0];
  end

  logic         inc, gs, to_inf;
  logic [M:0]   sum;
  logic [E+2:0] exp_r;

  always_comb begin
    gs = s1_q.guard | s1_q.sticky;
    unique case (s1_q.rmode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = !s1_q.sign & gs;
      2'b10:   inc = s1_q.sign & gs;
      default: inc = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
    endcase
    // Carry out of the fraction leaves sum[M-1:0] at zero, so only the exponent bumps.
    sum    = {1'b0, s1_q.mant} + {{M{1'b0}}, inc};
    exp_r  = {s1_q.exp[E+1], s1_q.exp} + {{(E+2){1'b0}}, sum[M]};
    to_inf = (s1_q.rmode == 2'b11) || (s1_q.rmode == 2'b01 && !s1_q.sign)
          || (s1_q.rmode == 2'b10 && s1_q.sign);

    res_n           = '0;
    res_n.sign      = s1_q.sign;
    res_n.exp       = exp_r[E-1:0];
    res_n.mant      = sum[M-1:0];
    res_n.inexact   = gs;
    if (s1_q.zero) begin
      res_n.exp     = '0;
      res_n.mant    = '0;
      res_n.inexact = 1'b0;
    end else if (!exp_r[E+2] && exp_r >= EXP_INF) begin
      res_n.overflow = 1'b1;
      res_n.inexact  = 1'b1;
      res_n.exp      = to_inf ? '1 : {{(E-1){1'b1}}, 1'b0};
      res_n.mant     = to_inf ? '0 : '1;
    end else if (exp_r[E+2] || exp_r == '0) begin
      res_n.underflow = 1'b1;
      res_n.inexact   = 1'b1;
      res_n.exp       = '0;
      res_n.mant      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      res_q    <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= bus.in_valid;
      if (in_ready && bus.in_valid) s1_q <= s1_n;
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
      if (s1_moves) res_q <= res_n;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = vld_pipe[2];
  assign bus.out_sign      = res_q.sign;
  assign bus.out_exp       = res_q.exp;
  assign bus.out_mant      = res_q.mant;
  assign bus.out_inexact   = res_q.inexact;
  assign bus.out_overflow  = res_q.overflow;
  assign bus.out_underflow = res_q.underflow;
endmodule
